// File: rtl/regfile_operand_stage_if.sv
// Operand-stage handshake bundle: upstream capture side and downstream buffer side.
interface regfile_operand_stage_if #(
    parameter int XLEN   = 32,
    parameter int NPORTS = 2,
    parameter int AW     = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NPORTS*AW-1:0]   raddr_in;
    logic [NPORTS*XLEN-1:0] rdata_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [NPORTS*AW-1:0]   raddr_buf;
    logic [NPORTS*XLEN-1:0] rdata_buf;

    modport master (
        output in_valid, raddr_in, rdata_in, out_ready,
        input  in_ready, out_valid, raddr_buf, rdata_buf
    );

    modport slave (
        input  in_valid, raddr_in, rdata_in, out_ready,
        output in_ready, out_valid, raddr_buf, rdata_buf
    );
endinterface

// File: rtl/regfile_operand_stage.sv
// Operand buffer between register-file read ports and execute,
// with valid/ready handshake, flush and write-back forwarding.
module regfile_operand_stage #(
    parameter int XLEN     = 32,
    parameter int NPORTS   = 2,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    regfile_operand_stage_if.slave bus
);

    logic                   valid_q, valid_d;
    logic [NPORTS*AW-1:0]   raddr_q, raddr_d;
    logic [NPORTS*XLEN-1:0] rdata_q, rdata_d;
    logic                   wb_hit;
    logic                   in_ready;
    logic                   do_cap, do_hold, do_drain;
    logic [NPORTS-1:0]      cap_hit, hold_hit;

    assign in_ready = !valid_q || bus.out_ready;
    // A write to the hardwired zero register must never reach the operands.
    assign wb_hit   = wb_we && !(ZERO_REG && (wb_addr == '0));

    assign do_cap   = !flush && bus.in_valid && in_ready;
    assign do_hold  = !flush && valid_q && !bus.out_ready;
    assign do_drain = !flush && valid_q && bus.out_ready && !bus.in_valid;

    always_comb begin
        cap_hit  = '0;
        hold_hit = '0;
        for (int p = 0; p < NPORTS; p++) begin
            cap_hit[p]  = wb_hit && (wb_addr == bus.raddr_in[p*AW +: AW]);
            hold_hit[p] = wb_hit && (wb_addr == raddr_q[p*AW +: AW]);
        end
    end

    always_comb begin
        valid_d = valid_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        unique case (1'b1)
            flush: begin
                valid_d = 1'b0;
                raddr_d = '0;
                rdata_d = '0;
            end
            do_cap: begin
                valid_d = 1'b1;
                raddr_d = bus.raddr_in;
                for (int p = 0; p < NPORTS; p++) begin
                    rdata_d[p*XLEN +: XLEN] = cap_hit[p] ? wb_data
                                            : bus.rdata_in[p*XLEN +: XLEN];
                end
            end
            do_hold: begin
                for (int p = 0; p < NPORTS; p++) begin
                    if (hold_hit[p]) rdata_d[p*XLEN +: XLEN] = wb_data;
                end
            end
            do_drain: begin
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.raddr_buf = raddr_q;
    assign bus.rdata_buf = rdata_q;

endmodule

// File: doc/regfile_operand_stage.md
Name: regfile_operand_stage

Overview:
Parametrised operand-buffer stage between the register-file read ports and execute. It holds NPORTS read operands for one pipeline slot, with a valid/ready handshake, synchronous flush, and write-back forwarding. Forwarding covers data captured in the same cycle as a write-back, and data held while the stage is stalled. It replaces the fixed two-port, always-enabled operand register.

Parameters:
XLEN, 32, data width of each operand
NPORTS, 2, number of read ports buffered (>=1)
AW, 5, register address width
ZERO_REG, 1, 1 = address 0 is hardwired zero; writes to address 0 are never forwarded

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-low
flush  input  1  synchronous flush; drops the buffered and incoming slot
in_valid  input  1  upstream presents operands
in_ready  output  1  stage can accept this cycle
raddr_in  input  NPORTS*AW  read addresses; port p at bits [p*AW +: AW]
rdata_in  input  NPORTS*XLEN  register-file read data; port p at [p*XLEN +: XLEN]
wb_we  input  1  write-back enable
wb_addr  input  AW  write-back address
wb_data  input  XLEN  write-back data
out_valid  output  1  buffered operands valid
out_ready  input  1  downstream consumes this cycle
raddr_buf  output  NPORTS*AW  buffered addresses
rdata_buf  output  NPORTS*XLEN  buffered operands

Behaviour:
- Reset (rstn=0, asynchronous): out_valid=0, raddr_buf=0, rdata_buf=0. Reset mid-transfer discards the slot.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid or flush.
- Define the match for port p against address a: wb_we && wb_addr==a && !(ZERO_REG && wb_addr==0).
- Priority per clock edge, highest first:
  1. flush=1: out_valid<=0, raddr_buf<=0, rdata_buf<=0. Any concurrent in_valid&&in_ready transfer is discarded.
  2. Capture (in_valid && in_ready):
     - out_valid<=1, raddr_buf<=raddr_in.
     - Per port: rdata_buf[p] <= match(raddr_in[p]) ? wb_data : rdata_in[p].
     - This is the write-before-read bypass for the same cycle.
  3. Hold (out_valid && !out_ready):
     - Per port: if match(raddr_buf[p]), rdata_buf[p]<=wb_data; else unchanged.
     - raddr_buf is unchanged.
  4. Drain (out_valid && out_ready && !(in_valid)):
     - out_valid<=0.
     - raddr_buf and rdata_buf retain their values; they are don't-care while invalid.
  5. Idle (!out_valid && !in_valid): no change.
- Latency: operands accepted at edge N are presented at out_valid from edge N to N+1.
- Throughput: one slot per cycle when out_ready=1 continuously (pass-through back-to-back).
- Several ports with the same matching address are all forwarded in the same cycle.
- Ports never interfere with each other.
- When ZERO_REG=1 and raddr==0, the data taken is rdata_in unchanged. The register file supplies 0, and this stage never overwrites it.
- When ZERO_REG=0, address 0 forwards like any other address.
- There is no combinational path from wb_* or rdata_in to the outputs. All outputs except in_ready are registered.

Test Plan:
1. Reset then pass-through, NPORTS=2, out_ready=1:
   - Stimulus: raddr_in={5,3}, rdata_in={0xAAAA0005,0x33333333}, in_valid=1 for 1 cycle.
   - Required: next cycle out_valid=1, rdata_buf={0xAAAA0005,0x33333333}; following cycle out_valid=0.
2. Same-cycle bypass:
   - Stimulus: capture raddr_in={7,7} with wb_we=1, wb_addr=7, wb_data=0xDEADBEEF, rdata_in={0x11,0x11}.
   - Required: both ports buffer 0xDEADBEEF.
3. Stall refresh:
   - Stimulus: hold out_ready=0 with raddr_buf={4,9}, then write wb_addr=9, wb_data=0x12345678.
   - Required:
     - rdata_buf port1 becomes 0x12345678 and port0 is unchanged.
     - in_ready=0 throughout the stall.
     - After out_ready=1 the updated value is consumed.
4. Zero register:
   - Stimulus: ZERO_REG=1, capture raddr_in={0,0} with wb_we=1, wb_addr=0, wb_data=0xFFFFFFFF, rdata_in=0.
   - Required: rdata_buf=0.
   - With ZERO_REG=0, the same stimulus gives 0xFFFFFFFF.
5. Flush:
   - Stimulus: with out_valid=1, out_ready=0, assert flush together with in_valid=1.
   - Required: next cycle out_valid=0, rdata_buf=0, and the incoming operands are lost.
6. Async reset mid-stall:
   - Stimulus: drop rstn between clock edges while out_valid=1.
   - Required: outputs go to 0 immediately with no clock edge.
   - After release, the first capture behaves as in scenario 1.
